if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage that produces the `pc_i`/`inst_i` pair consumed by the IF/ID pipeline register. It holds the architectural fetch PC, issues one word-fetch request at a time to the memory controller, and presents each returned instruction to IF/ID for exactly one cycle, with NOP bubbles in between. It honours the IF bit of the global stall vector and takes branch/jump redirects from EX, discarding any fetch already in flight.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INST`, 32'h0000_0013 (`addi x0,x0,0`), bubble driven on `inst_o` when no instruction is delivered.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `stall_signal`  in  `StallSignalLen`  global stall vector; bit 0 freezes this stage.
- `jump_flag`  in  1  redirect request from EX, single-cycle pulse.
- `jump_target`  in  32  redirect PC, valid with `jump_flag`.
- `mem_req_o`  out  1  fetch request to memory controller, level, held until ack.
- `mem_addr_o`  out  32  fetch address, stable while `mem_req_o`=1.
- `mem_ack_i`  in  1  one-cycle pulse: `mem_inst_i` valid this cycle.
- `mem_inst_i`  in  32  fetched instruction word.
- `pc_o`  out  32  PC of instruction on `inst_o`.
- `inst_o`  out  32  instruction to IF/ID, or `NOP_INST`.

## Operation
- State: `pc` (32), `buf_inst` (32), `discard` (1), FSM {FETCH, WAIT, HOLD}.
- Reset (async, `rst`=0): `pc`=`RESET_PC`, FSM=FETCH, `discard`=0, `mem_req_o`=0, `mem_addr_o`=0, `pc_o`=0, `inst_o`=`NOP_INST`.
- Priority each cycle: `jump_flag` > `mem_ack_i` > `stall_signal[0]`.
- FETCH: if `jump_flag`: `pc`<={`jump_target[31:2]`,2'b00}, stay FETCH. Else if `stall_signal[0]`: hold. Else: `mem_req_o`<=1, `mem_addr_o`<=`pc`, go WAIT.
- WAIT (`mem_req_o` held 1, address unchanged):
  - `jump_flag`, no ack: `pc`<=target, `discard`<=1, stay WAIT.
  - ack with `discard` or `jump_flag`: drop `mem_inst_i`, `mem_req_o`<=0, `discard`<=0, `pc`<=target if `jump_flag`, go FETCH.
  - ack, no discard, `stall_signal[0]`=0: deliver (`pc_o`<=`pc`, `inst_o`<=`mem_inst_i`), `pc`<=`pc`+4, `mem_req_o`<=0, go FETCH.
  - ack, no discard, `stall_signal[0]`=1: `buf_inst`<=`mem_inst_i`, `mem_req_o`<=0, go HOLD.
- HOLD: `jump_flag`: drop buffer, `pc`<=target, go FETCH. Else if `stall_signal[0]`=0: deliver `pc`/`buf_inst`, `pc`<=`pc`+4, go FETCH. Else hold.
- Delivery: `inst_o` carries the real instruction for exactly one cycle, then reverts to `NOP_INST`; `pc_o` retains last delivered PC.
- `pc`+4 wraps modulo 2^32; target low 2 bits forced to zero.

## Timing
- All outputs registered; no combinational input-to-output path.
- Fetch latency: request asserted the cycle after FETCH entry; delivery visible on `inst_o` the cycle after `mem_ack_i`. Zero-wait memory (ack one cycle after request) gives one instruction per 3 cycles.
- At most one request outstanding; `mem_req_o` falls the cycle after ack.
- Redirect is never applied to an in-flight request; stale word always dropped, next request uses target.
- `mem_ack_i` while `mem_req_o`=0 is ignored.
- Reset mid-WAIT abandons the request immediately; memory controller must tolerate a dropped request.

## Structure
- Shared defines file: `StallSignalLen`, `Zero`, `InstLen`, NOP encoding, FSM state encodings.
- Single module; no sub-module is natural.

## Test plan
- Reset release, ack 1 cycle after each req, words 0x11,0x22,0x33 -> `mem_addr_o` 0x0,0x4,0x8; `inst_o` shows each word for one cycle at `pc_o` 0x0,0x4,0x8, NOP otherwise.
- `stall_signal[0]`=1 for 4 cycles from the ack of 0x4 -> HOLD; 0x22 delivered the cycle after stall drops; next request addr 0x8.
- `jump_flag`, target 0x103, during WAIT on 0x8 -> returned word dropped, no delivery; next request addr 0x100.
- `jump_flag` same cycle as ack -> word dropped; next request at target.
- `rst` low mid-WAIT -> `mem_req_o`=0, `inst_o`=`NOP_INST` immediately; after release first request at `RESET_PC`.
- `pc`=0xFFFF_FFFC fetched -> next request addr 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and FSM encodings for the fetch stage
package if_fetch_pkg;

    localparam int StallSignalLen = 6;
    localparam int InstLen        = 32;
    localparam logic [31:0] Zero  = 32'h0000_0000;

    // addi x0,x0,0 bubble
    localparam logic [InstLen-1:0] NopInst = 32'h0000_0013;

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    // Redirect targets are word-aligned by clearing the two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory request/ack bus between fetch stage and memory controller
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic               mem_req_o;
    logic [31:0]        mem_addr_o;
    logic               mem_ack_i;
    logic [InstLen-1:0] mem_inst_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_inst_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_inst_i
    );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, single outstanding fetch, stall and redirect handling
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0]        RESET_PC = 32'h0000_0000,
    parameter logic [InstLen-1:0] NOP_INST = NopInst
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [StallSignalLen-1:0] stall_signal,
    input  logic                      jump_flag,
    input  logic [31:0]               jump_target,
    if_fetch_if.master                mem,
    output logic [31:0]               pc_o,
    output logic [InstLen-1:0]        inst_o
);

    logic [1:0]         state_q,   state_d;
    logic [31:0]        pc_q,      pc_d;
    logic [InstLen-1:0] buf_q,     buf_d;
    logic               discard_q, discard_d;
    logic               req_q,     req_d;
    logic [31:0]        addr_q,    addr_d;
    logic [31:0]        pc_out_q,  pc_out_d;
    logic [InstLen-1:0] inst_q,    inst_d;

    logic stall;
    assign stall = stall_signal[0];

    // Only bit 0 of the global stall vector belongs to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall_signal[StallSignalLen-1:1];

    // Next-state logic; inst_d defaults to the bubble so a delivery lasts one cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        discard_d = discard_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pc_out_d  = pc_out_q;
        inst_d    = NOP_INST;

        case (state_q)
            StFetch: begin
                if (jump_flag) begin
                    pc_d = align_pc(jump_target);
                end else if (!stall) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem.mem_ack_i) begin
                    req_d = 1'b0;
                    if (discard_q || jump_flag) begin
                        // Stale word from before a redirect: drop it.
                        discard_d = 1'b0;
                        if (jump_flag) begin
                            pc_d = align_pc(jump_target);
                        end
                        state_d = StFetch;
                    end else if (!stall) begin
                        pc_out_d = pc_q;
                        inst_d   = mem.mem_inst_i;
                        pc_d     = pc_q + 32'd4;
                        state_d  = StFetch;
                    end else begin
                        buf_d   = mem.mem_inst_i;
                        state_d = StHold;
                    end
                end else if (jump_flag) begin
                    // Request stays up; remember to throw away its data.
                    pc_d      = align_pc(jump_target);
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (jump_flag) begin
                    pc_d    = align_pc(jump_target);
                    state_d = StFetch;
                end else if (!stall) begin
                    pc_out_d = pc_q;
                    inst_d   = buf_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // State registers; reset abandons any outstanding request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            buf_q     <= NOP_INST;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= Zero;
            pc_out_q  <= Zero;
            inst_q    <= NOP_INST;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            pc_out_q  <= pc_out_d;
            inst_q    <= inst_d;
        end
    end

    assign mem.mem_req_o  = req_q;
    assign mem.mem_addr_o = addr_q;
    assign pc_o           = pc_out_q;
    assign inst_o         = inst_q;

endmodule
